// File: rtl/spi_status_monitor_pkg.sv
// Shared constants for the SPI status monitor: host register map, status bit
// positions and the default power-on status value.
package spi_status_monitor_pkg;

  localparam int unsigned STATUS_W = 8;
  localparam int unsigned ADDR_W   = 2;

  // Host register map
  localparam logic [ADDR_W-1:0] A_STATUS  = 2'd0;
  localparam logic [ADDR_W-1:0] A_EVENTS  = 2'd1;
  localparam logic [ADDR_W-1:0] A_MASK    = 2'd2;
  localparam logic [ADDR_W-1:0] A_FAILCNT = 2'd3;

  // Bit positions inside the STATUS byte
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_TX_COLL   = 3;
  localparam int unsigned ST_TX_EMPTY  = 4;
  localparam int unsigned ST_TX_EMPTY2 = 5;
  localparam int unsigned ST_RX_NEMPTY = 6;
  localparam int unsigned ST_CONN_FAIL = 7;

  // Idle status of the SPI core (both tx-empty flags set)
  localparam logic [STATUS_W-1:0] RESET_STATUS_DEF = 8'h30;

endpackage

// File: rtl/spi_status_monitor_status_sync.sv
// Multi-stage synchroniser with a programmable reset value.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into every stage
//   d     : asynchronous input bus
//   q     : synchronised output (last stage)
module spi_status_monitor_status_sync #(
  parameter int unsigned   STAGES    = 2,
  parameter int unsigned   W         = 8,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain_q [STAGES];

  // Shift chain; preloaded so that no spurious edge is seen after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        chain_q[i] <= RESET_VAL;
      end
    end else begin
      chain_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_status_monitor.sv
// SPI status monitor: synchronises the status byte, latches per-bit edges into
// sticky event flags, counts connection failures and raises a maskable IRQ.
//   S_CLK     : system clock
//   CLR_N     : asynchronous active-low reset
//   STATUS_IN : status byte from the SPI core
//   RD_EN     : host read strobe (ADDR selects register)
//   WR_EN     : host write strobe (only the mask register is writable)
//   ADDR      : 0 status, 1 events (clear-on-read), 2 mask, 3 fail count (clear-on-read)
//   WR_DATA   : mask write data
//   RD_DATA   : registered read data, held until the next read
//   RD_VALID  : one-cycle pulse qualifying RD_DATA
//   IRQ       : registered interrupt, |(events & mask)
module spi_status_monitor
  import spi_status_monitor_pkg::*;
#(
  parameter int unsigned          SYNC_STAGES  = 2,
  parameter logic [STATUS_W-1:0]  RESET_STATUS = RESET_STATUS_DEF,
  parameter logic [STATUS_W-1:0]  EDGE_SEL     = 8'hFF,
  parameter int unsigned          FAIL_CNT_W   = 8
) (
  input  logic                S_CLK,
  input  logic                CLR_N,
  input  logic [STATUS_W-1:0] STATUS_IN,
  input  logic                RD_EN,
  input  logic                WR_EN,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [STATUS_W-1:0] WR_DATA,
  output logic [STATUS_W-1:0] RD_DATA,
  output logic                RD_VALID,
  output logic                IRQ
);

  logic [STATUS_W-1:0]   s_stat;
  logic [STATUS_W-1:0]   prev_q;
  logic [STATUS_W-1:0]   hit;
  logic [STATUS_W-1:0]   events_q, events_d;
  logic [STATUS_W-1:0]   mask_q, mask_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [STATUS_W-1:0]   rd_mux;
  logic                  rd_events, rd_failcnt;

  spi_status_monitor_status_sync #(
    .STAGES    (SYNC_STAGES),
    .W         (STATUS_W),
    .RESET_VAL (RESET_STATUS)
  ) u_status_sync (
    .clk   (S_CLK),
    .rst_n (CLR_N),
    .d     (STATUS_IN),
    .q     (s_stat)
  );

  // Per-bit edge detect; EDGE_SEL picks rising (1) or falling (0)
  assign hit = (EDGE_SEL & s_stat & ~prev_q) | (~EDGE_SEL & ~s_stat & prev_q);

  assign rd_events  = RD_EN && (ADDR == A_EVENTS);
  assign rd_failcnt = RD_EN && (ADDR == A_FAILCNT);

  // Next-state for events, mask and fail counter; a same-cycle hit beats clear-on-read
  always_comb begin
    events_d   = rd_events ? hit : (events_q | hit);
    mask_d     = (WR_EN && (ADDR == A_MASK)) ? WR_DATA : mask_q;
    fail_cnt_d = fail_cnt_q;
    if (rd_failcnt) begin
      fail_cnt_d = hit[ST_CONN_FAIL] ? FAIL_CNT_W'(1) : '0;
    end else if (hit[ST_CONN_FAIL] && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
    end
  end

  // Read mux returns pre-clear values
  always_comb begin
    rd_mux = s_stat;
    case (ADDR)
      A_STATUS:  rd_mux = s_stat;
      A_EVENTS:  rd_mux = events_q;
      A_MASK:    rd_mux = mask_q;
      A_FAILCNT: rd_mux = STATUS_W'(fail_cnt_q);
      default:   rd_mux = s_stat;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge S_CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      prev_q     <= RESET_STATUS;
      events_q   <= '0;
      mask_q     <= '0;
      fail_cnt_q <= '0;
      RD_DATA    <= '0;
      RD_VALID   <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      prev_q     <= s_stat;
      events_q   <= events_d;
      mask_q     <= mask_d;
      fail_cnt_q <= fail_cnt_d;
      RD_VALID   <= RD_EN;
      if (RD_EN) begin
        RD_DATA <= rd_mux;
      end
      IRQ        <= |(events_d & mask_d);
    end
  end

endmodule
